sram_act_reader: RTL and testbench
==================================

SRAM_ACT_READER -- requirements
Module: sram_act_reader

Interface
REQ-001 Parameter: DATA_W, 32, SRAM word and stream width.
REQ-002 Parameter: ADDR_W, 16, SRAM port address width.
REQ-003 Parameter: LEN_W, 12, transfer length width in words.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first word address; captured on accepted start.
REQ-008 length  in  LEN_W  word count 0..2048; captured on accepted start.
REQ-009 busy  out  1  high from the edge after an accepted start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 sram_wea  out  4  byte write enables to activation SRAM port; constant 0.
REQ-012 sram_addr  out  ADDR_W  SRAM read address.
REQ-013 sram_wdata  out  DATA_W  constant 0.
REQ-014 sram_rdata  in  DATA_W  SRAM read data, valid one cycle after the address.
REQ-015 m_valid  out  1  stream beat valid.
REQ-016 m_data  out  DATA_W  stream beat data.
REQ-017 m_last  out  1  marks final beat of a transfer.
REQ-018 m_ready  in  1  downstream accept; a beat transfers on the edge where m_valid and m_ready are both high.

Function
REQ-019 The block SHALL implement states IDLE, READ, DRAIN.
- IDLE -> READ on start with length != 0.
- IDLE -> done pulse, stay IDLE, on start with length == 0.
- READ -> DRAIN after the last read is issued.
- DRAIN -> IDLE on the m_last handshake.
REQ-020 start SHALL be ignored in READ and DRAIN; captured base_addr and length SHALL NOT change.
REQ-021 Read issue: read i SHALL present sram_addr = {base_addr[15:11], (base_addr[10:0] + i) mod 2048}; lower 11 bits wrap, upper 5 bits are held.
REQ-022 The first read SHALL be issued in the cycle after the start-sampling edge; first m_valid SHALL rise 2 edges after that edge.
REQ-023 sram_rdata SHALL be captured into a 2-entry output FIFO on the edge after its address; no combinational path from sram_rdata to m_data.
REQ-024 A read SHALL issue only when in-flight reads plus FIFO occupancy < 2, so the FIFO never overflows.
- sram_addr SHALL hold its value while no read issues.
REQ-025 With m_ready held high, throughput SHALL be 1 word per cycle; a length-N transfer SHALL complete N+2 cycles after start.
REQ-026 m_data and m_last SHALL remain stable while m_valid is high and m_ready is low.
REQ-027 Beats SHALL be emitted in address order with no loss or duplication.
REQ-028 m_last SHALL be high only with beat number length-1.
REQ-029 done SHALL pulse on the edge after the m_last handshake; busy SHALL fall on the same edge.
REQ-030 A new start SHALL be accepted in the cycle done is high.
REQ-031 Length 2048 SHALL read every location exactly once.

Reset
REQ-032 While rst is high, the block SHALL hold:
- state IDLE, FIFO empty, in-flight count 0;
- busy, done, m_valid, m_last = 0;
- sram_addr = 0, m_data = 0.
REQ-033 Reset mid-transfer SHALL abort immediately, drop pending data, and emit no done.
- The first start after reset release SHALL operate normally.

Verification
REQ-034 Basic: base=0x0010, length=4, m_ready=1.
- sram_addr = 0x0010..0x0013 on consecutive cycles.
- m_data = mem[0x10..0x13], m_last on the 4th beat.
- done at start+6, sram_wea = 0 throughout.
REQ-035 Backpressure: length=8, m_ready low 5 cycles after beat 2.
- No more than 2 words are buffered or in flight; sram_addr holds.
- m_data stays stable; all 8 words arrive in order.
REQ-036 Wrap: base=0x07FE, length=4.
- Addresses 0x07FE, 0x07FF, 0x0000, 0x0001.
REQ-037 Zero length: start with length=0.
- done pulses the next cycle; m_valid never rises; busy stays 0.
REQ-038 Start while busy: a second start mid-transfer is ignored and the transfer completes unchanged.
- Reset asserted mid-transfer drives all outputs to 0 immediately.
- A fresh base=0x0100, length=2 transfer then completes correctly.

Source files
------------

// File: rtl/sram_act_reader.sv
// Streams a block of activation words from an SRAM read port onto a valid/ready stream.
// Reads run one cycle ahead of a 2-entry output FIFO; issue is credit-limited so the FIFO never overflows.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// READ  | issuing SRAM reads (addresses wrap in the low 11 bits)
// DRAIN | all reads issued, emptying the FIFO until the last beat is taken
module sram_act_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [3:0]        sram_wea,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);
    localparam int WRAP_W = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rd_left_q, rd_left_d;
    logic [LEN_W-1:0]  beat_left_q, beat_left_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              head_q, head_d;
    logic [DATA_W-1:0] fifo0_q, fifo0_d;
    logic [DATA_W-1:0] fifo1_q, fifo1_d;
    logic              done_q, done_d;

    logic       accept;
    logic       pop;
    logic       rd_en;
    logic [1:0] credit;

    assign accept = (state_q == S_IDLE) && start;
    assign pop    = m_valid && m_ready;
    // The beat leaving this cycle frees its slot before the new read can land.
    assign credit = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign rd_en  = (state_q == S_READ) && (credit < 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (length != '0)) state_d = S_READ;
            end
            S_READ: begin
                if (rd_en && (rd_left_q == LEN_W'(1))) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && m_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = done_q;
        sram_wea   = '0;
        sram_wdata = '0;
        sram_addr  = addr_q;
        m_valid    = (cnt_q != 2'd0);
        m_data     = head_q ? fifo1_q : fifo0_q;
        m_last     = m_valid && (beat_left_q == LEN_W'(1));
    end

    always_comb begin
        addr_d      = addr_q;
        rd_left_d   = rd_left_q;
        beat_left_d = beat_left_q;
        inflight_d  = rd_en;
        cnt_d       = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        head_d      = head_q;
        fifo0_d     = fifo0_q;
        fifo1_d     = fifo1_q;
        done_d      = 1'b0;

        if (accept) begin
            addr_d      = base_addr;
            rd_left_d   = length;
            beat_left_d = length;
            done_d      = (length == '0);
        end
        if (rd_en) begin
            addr_d    = {addr_q[ADDR_W-1:WRAP_W], addr_q[WRAP_W-1:0] + WRAP_W'(1)};
            rd_left_d = rd_left_q - LEN_W'(1);
        end
        if (inflight_q) begin
            if (head_q ^ cnt_q[0]) fifo1_d = sram_rdata;
            else                   fifo0_d = sram_rdata;
        end
        if (pop) begin
            head_d      = ~head_q;
            beat_left_d = beat_left_q - LEN_W'(1);
            if (m_last) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            rd_left_q   <= '0;
            beat_left_q <= '0;
            inflight_q  <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= 1'b0;
            fifo0_q     <= '0;
            fifo1_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rd_left_q   <= rd_left_d;
            beat_left_q <= beat_left_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            fifo0_q     <= fifo0_d;
            fifo1_q     <= fifo1_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_sram_act_reader.sv
// Self-checking bench for sram_act_reader: vector table, random transfers and hand-built corner sequences,
// all compared against an address/data model derived from the block's addressing rules.
module tb_sram_act_reader;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [11:0] length;
    logic        busy;
    logic        done;
    logic [3:0]  sram_wea;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    sram_act_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .sram_wea   (sram_wea),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       rx[$];
    int          k;
    int          acc;
    logic [15:0] cur_base;
    int          cur_len;
    bit          stalled;
    logic [31:0] hold_data;
    logic        hold_last;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [15:0] model_addr(input logic [15:0] b, input int i);
        int          lo;
        logic [15:0] r;
        lo = (int'(b[10:0]) + i) % 2048;
        r = b;
        r[10:0] = lo[10:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) sram_rdata <= mem_word(sram_addr);

    // Per-cycle protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            check("wea_zero", sram_wea, 0);
            check("wdata_zero", sram_wdata, 0);
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, hold_data);
                check("stall_last", m_last, hold_last);
            end
            if (!m_valid) check("last_without_valid", m_last, 0);
            if (busy) begin
                if (sram_addr !== model_addr(cur_base, k)) begin
                    if (k < cur_len) k++;
                    check("addr_seq", sram_addr, model_addr(cur_base, k));
                end
                check("outstanding_le2", ((k - acc) <= 2), 1);
            end
            if (m_valid && m_ready) begin
                rx.push_back('{data: m_data, last: m_last});
                acc++;
            end
            stalled   = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    // mode 0: ready always high, 1: random ready, 2: ready low 5 cycles after beat 2.
    // poke >= 0 drives a spurious start in that cycle of the transfer.
    task automatic run_xfer(input logic [15:0] base, input int len, input int mode, input int poke,
                            output int lat);
        int cyc;
        int stall;
        int first_v;
        int busy_err;
        int budget;
        rx.delete();
        k        = 0;
        acc      = 0;
        cur_base = base;
        cur_len  = len;
        start     = 1'b1;
        base_addr = base;
        length    = len[11:0];
        m_ready   = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ~base;
        length    = 12'($urandom_range(0, 4095));
        check("busy_after_start", busy, 1);
        check("first_addr", sram_addr, base);
        cyc = 0; stall = 0; first_v = -1; busy_err = 0; lat = -1;
        budget = 4 * len + 40;
        while (lat < 0 && cyc < budget) begin
            if (mode == 1) m_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && acc >= 2 && stall < 5) begin
                m_ready = 1'b0;
                stall++;
            end else m_ready = 1'b1;
            if (cyc == poke) begin
                start     = 1'b1;
                base_addr = 16'hDEAD;
                length    = 12'd3;
            end else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (first_v < 0 && m_valid) first_v = cyc;
            if (done) lat = cyc;
            else if (!busy) busy_err++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check("done_within_budget", (lat >= 0), 1);
        check("first_valid_edge", first_v, 2);
        check("busy_low_with_done", busy, 0);
        check("busy_during_xfer_errs", busy_err, 0);
        check("reads_issued", k, len);
        check("beat_count", rx.size(), len);
        for (int i = 0; i < rx.size() && i < len; i++) begin
            check("beat_data", rx[i].data, mem_word(model_addr(base, i)));
            check("beat_last", rx[i].last, (i == len - 1));
        end
    endtask

    typedef struct {
        logic [15:0] base;
        int          len;
        int          mode;
        logic [15:0] exp_last_addr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{16'h0010,    4, 0, 16'h0013,    6};
        vecs[1] = '{16'h07FE,    4, 0, 16'h0001,    6};
        vecs[2] = '{16'hF7FD,    5, 0, 16'hF001,    7};
        vecs[3] = '{16'h1234,    1, 0, 16'h1234,    3};
        vecs[4] = '{16'h0010,    8, 2, 16'h0017,   -1};
        vecs[5] = '{16'hABCD,   20, 1, 16'hABE0,   -1};
        vecs[6] = '{16'h2FFF,    3, 1, 16'h2801,   -1};
        vecs[7] = '{16'h0000, 2048, 0, 16'h07FF, 2050};

        rst = 1'b1; start = 1'b0; base_addr = 16'h0; length = 12'h0; m_ready = 1'b0;
        cur_base = 16'h0; cur_len = 0; k = 0; acc = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_data", m_data, 0);
        check("rst_wea", sram_wea, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: each start lands in the cycle where the previous done is high.
        for (int v = 0; v < 8; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, -1, lat);
            if (vecs[v].exp_lat >= 0) check("vec_latency", lat, vecs[v].exp_lat);
            if (rx.size() == vecs[v].len)
                check("vec_last_data", rx[vecs[v].len - 1].data, mem_word(vecs[v].exp_last_addr));
        end
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);

        for (int r = 0; r < 8; r++) begin
            logic [15:0] b;
            int          n;
            int          md;
            b  = 16'($urandom);
            n  = $urandom_range(1, 40);
            md = $urandom_range(0, 1);
            run_xfer(b, n, md, -1, lat);
            if (md == 0) check("rand_latency", lat, n + 2);
        end

        // Zero length.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0444; length = 12'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", m_valid, 0);
        @(posedge clk); #1;
        check("zero_done_drop", done, 0);
        check("zero_busy2", busy, 0);
        check("zero_valid2", m_valid, 0);

        // Start while busy is ignored.
        run_xfer(16'h0500, 6, 0, 3, lat);
        check("poke_latency", lat, 8);
        @(posedge clk); #1;
        check("poke_no_restart", busy, 0);

        // Reset mid-transfer.
        rx.delete(); k = 0; acc = 0; cur_base = 16'h0300; cur_len = 10;
        start = 1'b1; base_addr = 16'h0300; length = 12'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", m_valid, 0);
        check("abort_last", m_last, 0);
        check("abort_addr", sram_addr, 0);
        check("abort_data", m_data, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_xfer(16'h0100, 2, 0, -1, lat);
        check("post_reset_latency", lat, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
